// File: rtl/rtl_kernel_wizard_0_example_checker_pkg.sv
// Shared types and constants for the example number checker.
// Beat/keep geometry helpers mirror the generator's derivation rules.
package rtl_kernel_wizard_0_example_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int          KEEP_MAX_W = 1024;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  // Right-shifting Galois mask for x^16 + x^15 + x^13 + x^4 + 1
  localparam logic [15:0] LFSR_TAPS  = 16'hD008;

  function automatic int calc_num_beats(input int len_bytes, input int beat_bytes);
    return (len_bytes + beat_bytes - 1) / beat_bytes;
  endfunction

  function automatic logic [KEEP_MAX_W-1:0] calc_final_keep(input int len_bytes, input int beat_bytes);
    logic [KEEP_MAX_W-1:0] keep;
    int rem;
    rem  = len_bytes % beat_bytes;
    keep = '0;
    for (int i = 0; i < KEEP_MAX_W; i++) begin
      if (i < beat_bytes && (rem == 0 || i < rem)) keep[i] = 1'b1;
      else keep[i] = 1'b0;
    end
    return keep;
  endfunction

endpackage

// File: rtl/rtl_kernel_wizard_0_example_lfsr.sv
// Galois LFSR used as a pseudo-random backpressure source.
// Reload has priority over stepping; stepping only while i_clken is high.
module rtl_kernel_wizard_0_example_lfsr #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] TAPS  = {WIDTH{1'b1}}
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clken,
  input  logic             i_reload,
  output logic [WIDTH-1:0] o_value
);

  logic [WIDTH-1:0] r_lfsr;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_reload) r_lfsr <= SEED;
    else if (i_clken)      r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : {WIDTH{1'b0}});
    else                   r_lfsr <= r_lfsr;
  end

  assign o_value = r_lfsr;

endmodule

// File: rtl/rtl_kernel_wizard_0_example_number_checker.sv
// AXI4-Stream sink verifying the example generator's incrementing-number stream.
// Define NUMBER_CHECKER_THROTTLE_EN to add LFSR-driven backpressure on s_axis_tready.
module rtl_kernel_wizard_0_example_number_checker
  import rtl_kernel_wizard_0_example_checker_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH = 128,
  parameter int C_NUMBER_BIT_WIDTH   = 32,
  parameter int C_LENGTH_IN_BYTES    = 16384
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic                              ap_start,
  output logic                              ap_done,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                              s_axis_tlast,
  output logic                              error,
  output logic [31:0]                       error_count,
  output logic [31:0]                       beat_count
);

  localparam int NBW        = (C_NUMBER_BIT_WIDTH < C_S_AXIS_TDATA_WIDTH) ? C_NUMBER_BIT_WIDTH : C_S_AXIS_TDATA_WIDTH;
  localparam int LANES      = C_S_AXIS_TDATA_WIDTH / NBW;
  localparam int BYTES      = C_S_AXIS_TDATA_WIDTH / 8;
  localparam int LANE_BYTES = NBW / 8;
  localparam int NUM_BEATS  = calc_num_beats(C_LENGTH_IN_BYTES, BYTES);
  localparam logic [KEEP_MAX_W-1:0] FINAL_KEEP_ALL = calc_final_keep(C_LENGTH_IN_BYTES, BYTES);
  localparam logic [BYTES-1:0]      FINAL_KEEP     = FINAL_KEEP_ALL[BYTES-1:0];
  localparam logic [31:0]           LAST_BEAT      = 32'(NUM_BEATS - 1);
  localparam logic [NBW-1:0]        LANE_STEP      = NBW'(LANES);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_ap_start;
  logic             r_error;
  logic [31:0]      r_error_count;
  logic [31:0]      r_beat_count;
  logic [NBW-1:0]   r_exp_base;
  logic             w_start;
  logic             w_start_idle;
  logic             w_hs;
  logic             w_is_last;
  logic             w_terminate;
  logic             w_mismatch;
  logic             w_throttle_ok;
  logic [BYTES-1:0] w_exp_keep;
  logic [LANES-1:0] w_lane_err;

  assign w_start      = ap_start & ~r_ap_start;
  assign w_start_idle = w_start & (r_state == IDLE);
  assign w_hs         = s_axis_tvalid & s_axis_tready;
  assign w_is_last    = (r_beat_count == LAST_BEAT);
  assign w_terminate  = w_is_last | s_axis_tlast;
  assign w_exp_keep   = w_is_last ? FINAL_KEEP : {BYTES{1'b1}};

`ifdef NUMBER_CHECKER_THROTTLE_EN
  logic [15:0] w_lfsr;

  rtl_kernel_wizard_0_example_lfsr #(
    .WIDTH (16),
    .SEED  (LFSR_SEED),
    .TAPS  (LFSR_TAPS)
  ) u_lfsr (
    .i_clk    (aclk),
    .i_rst    (areset),
    .i_clken  (r_state == RUN),
    .i_reload (w_start_idle),
    .o_value  (w_lfsr)
  );

  assign w_throttle_ok = (w_lfsr[1:0] != 2'b00);
`else
  assign w_throttle_ok = 1'b1;
`endif

  // Only lanes whose bytes are all kept are data-checked; tkeep itself is checked separately
  for (genvar n = 0; n < LANES; n++) begin : g_lane
    logic [NBW-1:0] w_exp;
    logic           w_keep_full;
    assign w_exp         = r_exp_base + NBW'(n);
    assign w_keep_full   = &s_axis_tkeep[n*LANE_BYTES +: LANE_BYTES];
    assign w_lane_err[n] = w_keep_full && (s_axis_tdata[n*NBW +: NBW] != w_exp);
  end

  assign w_mismatch = (|w_lane_err) | (s_axis_tkeep != w_exp_keep) | (s_axis_tlast != w_is_last);

  always_ff @(posedge aclk) begin
    if (areset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next_state = RUN;  else w_next_state = IDLE;
      RUN:     if (w_hs && w_terminate) w_next_state = DONE; else w_next_state = RUN;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    ap_done       = 1'b0;
    s_axis_tready = 1'b0;
    case (r_state)
      RUN:     s_axis_tready = w_throttle_ok;
      DONE:    ap_done       = 1'b1;
      default: s_axis_tready = 1'b0;
    endcase
  end

  // Run statistics: cleared on an accepted start, updated on every handshake
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_ap_start    <= 1'b0;
      r_error       <= 1'b0;
      r_error_count <= 32'd0;
      r_beat_count  <= 32'd0;
      r_exp_base    <= '0;
    end else begin
      r_ap_start <= ap_start;
      if (w_start_idle) begin
        r_error       <= 1'b0;
        r_error_count <= 32'd0;
        r_beat_count  <= 32'd0;
        r_exp_base    <= '0;
      end else if (w_hs) begin
        r_beat_count <= r_beat_count + 32'd1;
        r_exp_base   <= r_exp_base + LANE_STEP;
        if (w_mismatch) begin
          r_error <= 1'b1;
          if (r_error_count != 32'hFFFF_FFFF) r_error_count <= r_error_count + 32'd1;
        end
      end
    end
  end

  assign error       = r_error;
  assign error_count = r_error_count;
  assign beat_count  = r_beat_count;

endmodule

// File: doc/rtl_kernel_wizard_0_example_number_checker.md
Name: rtl_kernel_wizard_0_example_number_checker

Overview:
AXI4-Stream sink that consumes the incrementing-number stream produced by the example number generator and verifies it in-line.
- Checks every beat for lane data, tkeep, and tlast position against the generator's deterministic pattern.
- Reports a sticky error flag, a saturating mismatch count, and a one-cycle ap_done when the transfer completes.
- Sits directly downstream of the generator in the example kernel datapath.

Parameters:
- C_S_AXIS_TDATA_WIDTH, 128, stream data width in bits; multiple of C_NUMBER_BIT_WIDTH.
- C_NUMBER_BIT_WIDTH, 32, width of one number lane.
- C_LENGTH_IN_BYTES, 16384, expected transfer length in bytes.

Ports:
- aclk  in  1  clock; all logic rising-edge.
- areset  in  1  reset; synchronous, active-high.
- ap_start  in  1  level; a rising edge arms the checker.
- ap_done  out  1  one-cycle pulse when the transfer terminates.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tready  out  1  stream ready.
- s_axis_tdata  in  C_S_AXIS_TDATA_WIDTH  stream data.
- s_axis_tkeep  in  C_S_AXIS_TDATA_WIDTH/8  byte keep.
- s_axis_tlast  in  1  last beat.
- error  out  1  sticky mismatch flag for the current run.
- error_count  out  32  saturating count of beats with any mismatch.
- beat_count  out  32  beats accepted in the current run.

Behaviour:
- Derived constants (same rules as the generator):
  - NBW = min(C_NUMBER_BIT_WIDTH, TDATA width).
  - LANES = TDATA/NBW.
  - BYTES = TDATA/8.
  - NUM_BEATS = ceil(C_LENGTH_IN_BYTES/BYTES).
  - FINAL_KEEP = (1 << (C_LENGTH_IN_BYTES % BYTES)) - 1 if a partial beat exists, else all ones.
- Reset values: ap_done=0, s_axis_tready=0, error=0, error_count=0, beat_count=0, state=IDLE, expected beat index=0.
- Start detection: ap_start is registered; start = ap_start & ~ap_start_r.
- FSM states:
  - IDLE: tready=0. On start, go to RUN; clear error, error_count, beat_count and the expected index in the same edge.
  - RUN: tready=1 (see Optional Feature). A handshake occurs when tvalid & tready.
    - On each handshake, compare against beat index b. Expected lane n = (b*LANES + n) mod 2^NBW.
    - Data is compared only for lanes whose keep bytes are all 1.
    - Expected tkeep = FINAL_KEEP if b == NUM_BEATS-1, else all ones.
    - Expected tlast = (b == NUM_BEATS-1).
    - Any mismatch on a beat: error <= 1; error_count += 1, saturating at 0xFFFFFFFF. Multiple mismatches on one beat count once.
    - beat_count increments on every handshake.
    - Termination: a handshake with b == NUM_BEATS-1 or with tlast=1 (an early tlast is also an error) goes to DONE.
  - DONE: one cycle only. ap_done=1, tready=0, then IDLE.
- Latency: ap_done asserts exactly one cycle after the terminating handshake. error and error_count are updated on the handshake edge.
- Wrap-around: the expected-index counter wraps modulo 2^NBW, identical to the generator counters.
- A start arriving in RUN or DONE is ignored; only IDLE responds.
- areset mid-run returns all state and outputs to their reset values on the next edge. Stream data present during reset is dropped (tready=0).
- tvalid while IDLE stalls upstream because tready=0; no data is consumed.
- tdata, tkeep and tlast are ignored when tvalid=0.

Optional Feature:
- Macro: NUMBER_CHECKER_THROTTLE_EN.
- Defined:
  - A 16-bit Galois LFSR with taps 16,15,13,4 and seed 0xACE1 advances every cycle in RUN; it reloads the seed in reset and on start.
  - s_axis_tready = RUN & (lfsr[1:0] != 2'b00), giving about 25% backpressure to exercise the upstream tready path.
- Undefined: s_axis_tready = (state == RUN); no LFSR logic is instantiated.

Decomposition:
- Package rtl_kernel_wizard_0_example_checker_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - functions computing NUM_BEATS and FINAL_KEEP from the parameters;
  - the LFSR seed and tap constants.
- Sub-module rtl_kernel_wizard_0_example_lfsr (parameterized width, seed, taps; clken and reload inputs) holds the throttle generator. It is only instantiated under the macro.
- Lane comparison stays in a generate loop in the top module.

Test Plan:
1. Defaults (1024 beats). Pulse ap_start, then drive the correct pattern (beat 0 = lanes {3,2,1,0}), tlast on beat 1023 -> ap_done one cycle after the final handshake; error=0, beat_count=1024.
2. Corrupt lane 2 of beat 5 (value 0x16 replaced by 0x00) -> error=1 from the beat-5 edge onward; error_count=1; ap_done still pulses after beat 1023.
3. Assert tlast on beat 10 -> transfer terminates with ap_done; error=1, error_count=1, beat_count=11.
4. C_LENGTH_IN_BYTES=20: beat 1 has tkeep=0x000F and tlast -> no error; the same beat with tkeep=0xFFFF -> error_count=1.
5. Assert areset for 1 cycle at beat 300 -> tready=0 and all outputs 0 next cycle; a new start then checks from beat index 0 again.
6. With NUMBER_CHECKER_THROTTLE_EN and tvalid held high -> tready low on about 25% of cycles; data accepted in order; error=0; ap_done after 1024 handshakes.
